// File: rtl/eyeriss_conv_core_if.sv
// eyeriss_conv_core_if: start/done handshake and layer shape for the conv core.
interface eyeriss_conv_core_if;
    logic       i_ap_start;
    logic       o_ap_done;
    logic [7:0] i_layer_HW;
    logic [3:0] i_layer_RS;
    logic [6:0] i_layer_EF;
    logic [9:0] i_layer_C;
    logic [8:0] i_layer_M;
    logic [1:0] i_layer_U;
    logic [1:0] i_layer_PAD;
    logic [4:0] i_layer_p;
    modport master (output i_ap_start, i_layer_HW, i_layer_RS, i_layer_EF, i_layer_C,
                    i_layer_M, i_layer_U, i_layer_PAD, i_layer_p, input o_ap_done);
    modport slave (input i_ap_start, i_layer_HW, i_layer_RS, i_layer_EF, i_layer_C,
                   i_layer_M, i_layer_U, i_layer_PAD, i_layer_p, output o_ap_done);
endinterface

// File: rtl/eyeriss_conv_core.sv
// eyeriss_conv_core: banked global buffer plus a one-MAC-per-cycle convolution controller.
module glb_bank #(parameter int DW = 32, parameter int DEPTH = 512, parameter int AW = $clog2(DEPTH)) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);
    logic [DW-1:0] BRAM [DEPTH];
    always_ff @(posedge clk) begin
        if (we) BRAM[waddr] <= wdata;
        if (re) rdata <= BRAM[raddr];
    end
endmodule

module glb #(parameter int DW = 32, parameter int N = 3, parameter int DEPTH = 512, parameter int AW = $clog2(DEPTH)) (
    input  logic                  clk,
    input  logic [N-1:0]          re,
    input  logic [N-1:0][AW-1:0]  raddr,
    output logic [N-1:0][DW-1:0]  rdata,
    input  logic [N-1:0]          we,
    input  logic [N-1:0][AW-1:0]  waddr,
    input  logic [N-1:0][DW-1:0]  wdata
);
    for (genvar k = 0; k < N; k++) begin : gen_GLB_BANKS
        glb_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) glb_bank_inst (
            .clk(clk), .re(re[k]), .raddr(raddr[k]), .rdata(rdata[k]),
            .we(we[k]), .waddr(waddr[k]), .wdata(wdata[k]));
    end
endmodule

module eyeriss_conv_core #(
    parameter int DATA_BITWIDTH = 32,
    parameter int BANK_NUM      = 3,
    parameter int BANK_DEPTH    = 512
) (
    input logic i_clk,
    input logic i_rst,
    eyeriss_conv_core_if.slave bus
);
    localparam int DW = DATA_BITWIDTH;
    localparam int AW = $clog2(BANK_DEPTH);
    typedef enum logic [2:0] {IDLE, INIT, MAC, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic [BANK_NUM-1:0] re, we;
    logic [BANK_NUM-1:0][AW-1:0] raddr, waddr;
    logic [BANK_NUM-1:0][DW-1:0] rdata, wdata;
    logic [7:0] hw;
    logic [3:0] rs, r, s;
    logic [6:0] ef, e, f;
    logic [9:0] ch, c;
    logic [8:0] mm, m;
    logic [1:0] u, pad;
    logic [4:0] p;
    logic fin, psum_v, tap_v, start, pad_tap, s_end, r_end, f_end, e_end, tap_last, out_last;
    logic signed [31:0] h, w;
    logic [AW-1:0] if_addr, w_addr, idx, out_addr;
    logic [DW-1:0] acc;

    glb #(.DW(DW), .N(BANK_NUM), .DEPTH(BANK_DEPTH), .AW(AW)) u_GLB (
        .clk(i_clk), .re(re), .raddr(raddr), .rdata(rdata), .we(we), .waddr(waddr), .wdata(wdata));

    assign start    = bus.i_ap_start && (state == IDLE || state == DONE);
    assign h        = 32'(e) * 32'(u) + 32'(r) - 32'(pad);
    assign w        = 32'(f) * 32'(u) + 32'(s) - 32'(pad);
    assign pad_tap  = h < 0 || h >= $signed(32'(hw)) || w < 0 || w >= $signed(32'(hw));
    assign if_addr  = AW'((32'(c) * 32'(hw) + $unsigned(h)) * 32'(hw) + $unsigned(w));
    assign w_addr   = AW'(((32'(m) * 32'(ch) + 32'(c)) * 32'(rs) + 32'(r)) * 32'(rs) + 32'(s));
    assign idx      = AW'((32'(m) * 32'(ef) + 32'(e)) * 32'(ef) + 32'(f));
    assign out_addr = AW'(32'(ef) * 32'(ef) * 32'(p)) + idx;
    assign s_end    = s == rs - 4'd1;
    assign r_end    = r == rs - 4'd1;
    assign f_end    = f == ef - 7'd1;
    assign e_end    = e == ef - 7'd1;
    assign tap_last = s_end && r_end && c == ch - 10'd1;
    assign out_last = f_end && e_end && m == mm - 9'd1;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (bus.i_ap_start)
                state_nx = (bus.i_layer_M == 9'd0 || bus.i_layer_EF == 7'd0) ? DONE : INIT;
            INIT:    state_nx = MAC;
            MAC:     state_nx = fin ? WRITE : MAC;
            WRITE:   state_nx = out_last ? DONE : INIT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.o_ap_done = state == DONE;
        re = '0;
        raddr = '0;
        we = '0;
        waddr = '0;
        wdata = '0;
        re[1] = state == INIT;
        raddr[1] = idx;
        re[0] = state == MAC && !fin && !pad_tap;
        re[2] = re[0];
        raddr[0] = if_addr;
        raddr[2] = w_addr;
        we[1] = state == WRITE;
        waddr[1] = out_addr;
        wdata[1] = acc;
    end

    // Read data lands one cycle after issue, so the valid flags trail the read enables.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            {hw, rs, ef, ch, mm, u, pad, p} <= '0;
            {m, e, f, c, r, s} <= '0;
            {fin, psum_v, tap_v} <= '0;
            acc <= '0;
        end else begin
            psum_v <= re[1];
            tap_v <= re[0];
            if (psum_v) acc <= rdata[1];
            else if (tap_v) acc <= acc + rdata[0] * rdata[2];
            if (start) begin
                {hw, rs, ef, ch} <= {bus.i_layer_HW, bus.i_layer_RS, bus.i_layer_EF, bus.i_layer_C};
                {mm, u, pad, p} <= {bus.i_layer_M, bus.i_layer_U, bus.i_layer_PAD, bus.i_layer_p};
                {m, e, f} <= '0;
            end
            if (state == INIT) begin
                {c, r, s} <= '0;
                fin <= ch == 10'd0 || rs == 4'd0;
            end else if (state == MAC && !fin) begin
                fin <= tap_last;
                s <= s_end ? 4'd0 : s + 4'd1;
                r <= s_end ? (r_end ? 4'd0 : r + 4'd1) : r;
                c <= s_end && r_end ? c + 10'd1 : c;
            end
            if (state == WRITE) begin
                f <= f_end ? 7'd0 : f + 7'd1;
                e <= f_end ? (e_end ? 7'd0 : e + 7'd1) : e;
                m <= f_end && e_end ? m + 9'd1 : m;
            end
        end
endmodule

// File: tb/tb_eyeriss_conv_core.sv
// tb_eyeriss_conv_core: directed layers preloaded by backdoor, results read from the psum bank.
module tb_eyeriss_conv_core;
    logic clk = 0;
    logic rst = 1;
    int total = 0;
    int bad = 0;
    int chw, crs, cef, cc, cm, cu, cpad, cp;
    logic [31:0] sh [3][512];
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    eyeriss_conv_core_if bus();
    eyeriss_conv_core dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic load(input int b, input int a, input logic [31:0] v);
        sh[b][a] = v;
        if (b == 0) dut.u_GLB.gen_GLB_BANKS[0].glb_bank_inst.BRAM[a] <= v;
        else if (b == 1) dut.u_GLB.gen_GLB_BANKS[1].glb_bank_inst.BRAM[a] <= v;
        else dut.u_GLB.gen_GLB_BANKS[2].glb_bank_inst.BRAM[a] <= v;
    endtask

    function automatic logic [31:0] rd1(input int a);
        return dut.u_GLB.gen_GLB_BANKS[1].glb_bank_inst.BRAM[a];
    endfunction

    task automatic cfg(input int hw_, input int rs_, input int ef_, input int c_, input int m_,
                       input int u_, input int pad_, input int p_);
        {chw, crs, cef, cc, cm, cu, cpad, cp} = {hw_, rs_, ef_, c_, m_, u_, pad_, p_};
        bus.i_layer_HW = 8'(hw_);
        bus.i_layer_RS = 4'(rs_);
        bus.i_layer_EF = 7'(ef_);
        bus.i_layer_C = 10'(c_);
        bus.i_layer_M = 9'(m_);
        bus.i_layer_U = 2'(u_);
        bus.i_layer_PAD = 2'(pad_);
        bus.i_layer_p = 5'(p_);
    endtask

    // Fill ifmap, weights and psum_init with constants and mark the output window.
    task automatic fill(input logic [31:0] iv, input logic [31:0] wv, input logic [31:0] pv);
        for (int i = 0; i < cc * chw * chw; i++) load(0, i, iv);
        for (int i = 0; i < cm * cc * crs * crs; i++) load(2, i, wv);
        for (int i = 0; i < cm * cef * cef; i++) load(1, i, pv);
        for (int i = 0; i <= cm * cef * cef; i++) load(1, cef * cef * cp + i, SENT);
        @(negedge clk);
    endtask

    task automatic pulse_start;
        bus.i_ap_start = 1;
        @(negedge clk);
        bus.i_ap_start = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.o_ap_done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.o_ap_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout got=%b want=1", name, bus.o_ap_done);
        end
    endtask

    function automatic logic [31:0] golden(input int m, input int e, input int f);
        logic [31:0] a;
        a = sh[1][(m * cef + e) * cef + f];
        for (int c = 0; c < cc; c++)
            for (int r = 0; r < crs; r++)
                for (int s = 0; s < crs; s++) begin
                    int h, w;
                    h = e * cu + r - cpad;
                    w = f * cu + s - cpad;
                    if (h >= 0 && h < chw && w >= 0 && w < chw)
                        a = a + sh[0][(c * chw + h) * chw + w] * sh[2][((m * cc + c) * crs + r) * crs + s];
                end
        return a;
    endfunction

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_ap_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", bus.o_ap_done);
        end
        rst = 0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.o_ap_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_done got=%b want=0", bus.o_ap_done);
        end
    endtask

    task automatic test_reference;
        cfg(5, 3, 3, 5, 4, 1, 0, 4);
        for (int i = 0; i < 125; i++) load(0, i, $urandom);
        for (int i = 0; i < 180; i++) load(2, i, $urandom);
        for (int i = 0; i < 36; i++) load(1, i, $urandom);
        for (int i = 36; i <= 72; i++) load(1, i, SENT);
        @(negedge clk);
        pulse_start;
        wait_done("reference");
        for (int m = 0; m < 4; m++)
            for (int e = 0; e < 3; e++)
                for (int f = 0; f < 3; f++) begin
                    logic [31:0] got, exp;
                    got = rd1(36 + (m * 3 + e) * 3 + f);
                    exp = golden(m, e, f);
                    total++;
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL reference_out m=%0d e=%0d f=%0d got=%h want=%h", m, e, f, got, exp);
                    end
                end
        total++;
        if (rd1(72) !== SENT) begin
            bad++;
            $display("FAIL reference_beyond_window got=%h want=%h", rd1(72), SENT);
        end
    endtask

    task automatic test_all_ones;
        cfg(5, 3, 3, 5, 4, 1, 0, 4);
        fill(1, 1, 0);
        pulse_start;
        wait_done("ones");
        for (int i = 0; i < 72; i++) begin
            logic [31:0] exp;
            exp = i < 36 ? 32'd0 : 32'd45;
            total++;
            if (rd1(i) !== exp) begin
                bad++;
                $display("FAIL ones_bank1 addr=%0d got=%0d want=%0d", i, rd1(i), exp);
            end
        end
    endtask

    task automatic test_padding;
        cfg(5, 3, 5, 5, 1, 1, 1, 1);
        fill(1, 1, 0);
        pulse_start;
        wait_done("padding");
        for (int e = 0; e < 5; e++)
            for (int f = 0; f < 5; f++) begin
                int edges;
                logic [31:0] exp;
                edges = int'(e == 0 || e == 4) + int'(f == 0 || f == 4);
                exp = edges == 2 ? 32'd20 : edges == 1 ? 32'd30 : 32'd45;
                total++;
                if (rd1(25 + e * 5 + f) !== exp) begin
                    bad++;
                    $display("FAIL padding_out e=%0d f=%0d got=%0d want=%0d", e, f, rd1(25 + e * 5 + f), exp);
                end
            end
    endtask

    task automatic test_stride;
        logic [31:0] exp [4];
        exp = '{32'd54, 32'd72, 32'd144, 32'd162};
        cfg(5, 3, 2, 1, 1, 2, 0, 1);
        fill(0, 1, 0);
        for (int i = 0; i < 25; i++) load(0, i, i);
        @(negedge clk);
        pulse_start;
        wait_done("stride");
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd1(4 + i) !== exp[i]) begin
                bad++;
                $display("FAIL stride_out idx=%0d got=%0d want=%0d", i, rd1(4 + i), exp[i]);
            end
        end
        repeat (5) @(negedge clk);
        total++;
        if (bus.o_ap_done !== 1'b1) begin
            bad++;
            $display("FAIL done_hold got=%b want=1", bus.o_ap_done);
        end
    endtask

    task automatic test_negative_busy;
        cfg(5, 3, 3, 5, 4, 1, 0, 4);
        fill(32'hFFFFFFFF, 2, 7);
        pulse_start;
        total++;
        if (bus.o_ap_done !== 1'b0) begin
            bad++;
            $display("FAIL done_clear_on_start got=%b want=0", bus.o_ap_done);
        end
        repeat (10) @(negedge clk);
        bus.i_layer_M = 9'd1;
        bus.i_layer_C = 10'd1;
        bus.i_layer_p = 5'd0;
        pulse_start;
        wait_done("negative");
        for (int i = 36; i < 72; i++) begin
            total++;
            if (rd1(i) !== 32'hFFFFFFAD) begin
                bad++;
                $display("FAIL negative_out addr=%0d got=%h want=ffffffad", i, rd1(i));
            end
        end
        total++;
        if (rd1(0) !== 32'd7) begin
            bad++;
            $display("FAIL busy_start_ignored addr0 got=%h want=7", rd1(0));
        end
    endtask

    task automatic test_reset_mid;
        cfg(5, 3, 3, 5, 4, 1, 0, 4);
        fill(1, 1, 0);
        pulse_start;
        repeat (200) @(negedge clk);
        #2 rst = 1;
        #1;
        total++;
        if (bus.o_ap_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_done got=%b want=0", bus.o_ap_done);
        end
        @(negedge clk);
        rst = 0;
        total++;
        if (rd1(36) !== 32'd45 || rd1(71) !== SENT) begin
            bad++;
            $display("FAIL midreset_partial got=%h,%h want=%h,%h", rd1(36), rd1(71), 32'd45, SENT);
        end
        repeat (2000) @(negedge clk);
        total++;
        if (bus.o_ap_done !== 1'b0 || rd1(71) !== SENT) begin
            bad++;
            $display("FAIL midreset_stays_idle done=%b last=%h want=0,%h", bus.o_ap_done, rd1(71), SENT);
        end
        pulse_start;
        wait_done("restart");
        for (int i = 36; i < 72; i++) begin
            total++;
            if (rd1(i) !== 32'd45) begin
                bad++;
                $display("FAIL restart_out addr=%0d got=%0d want=45", i, rd1(i));
            end
        end
    endtask

    initial begin
        bus.i_ap_start = 0;
        cfg(0, 0, 0, 0, 0, 1, 0, 0);
        test_reset;
        test_reference;
        test_all_ones;
        test_padding;
        test_stride;
        test_negative_busy;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
